// File: rtl/par_to_ser_reader.sv
// Parallel-to-serial reader: snapshots a register word on capture and streams it
// out one bit per valid/ready transfer, marking the first bit and the end of the frame.
module par_to_ser_reader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             capture,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_count;
  logic             r_serialOut;
  logic             r_serialValid;
  logic             r_frameStart;
  logic             r_frameDone;
  logic             r_busy;
  logic             r_overrun;

  logic [WIDTH-1:0] w_shifted;
  logic             w_nextHead;
  logic             w_captureHead;
  logic             w_last;

  // The head bit always sits at one end of the register; shifting moves the next bit into it.
  assign w_shifted     = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
  assign w_nextHead    = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];
  assign w_captureHead = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
  assign w_last        = (r_count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_count       <= '0;
      r_serialOut   <= 1'b0;
      r_serialValid <= 1'b0;
      r_frameStart  <= 1'b0;
      r_frameDone   <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (clear) begin
        r_state       <= IDLE;
        r_shift       <= '0;
        r_count       <= '0;
        r_serialOut   <= 1'b0;
        r_serialValid <= 1'b0;
        r_frameStart  <= 1'b0;
        r_busy        <= 1'b0;
        r_overrun     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (capture) begin
              r_state       <= SHIFT;
              r_shift       <= data_in;
              r_count       <= '0;
              r_serialOut   <= w_captureHead;
              r_serialValid <= 1'b1;
              r_frameStart  <= 1'b1;
              r_busy        <= 1'b1;
            end
          end
          SHIFT: begin
            // A capture during a frame is dropped but remembered until clear.
            if (capture) begin
              r_overrun <= 1'b1;
            end
            if (ready) begin
              r_shift      <= w_shifted;
              r_frameStart <= 1'b0;
              if (w_last) begin
                r_state       <= IDLE;
                r_count       <= '0;
                r_serialOut   <= 1'b0;
                r_serialValid <= 1'b0;
                r_busy        <= 1'b0;
                r_frameDone   <= 1'b1;
              end else begin
                r_count     <= r_count + 1'b1;
                r_serialOut <= w_nextHead;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign serial_out   = r_serialOut;
  assign serial_valid = r_serialValid;
  assign frame_start  = r_frameStart;
  assign frame_done   = r_frameDone;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_par_to_ser_reader.sv
// Self-checking bench for par_to_ser_reader: an MSB-first and an LSB-first instance
// share stimulus and are compared every cycle against a frame-level reference model.
module tb_par_to_ser_reader;

  localparam int W = 8;

  logic         clock   = 1'b0;
  logic         reset   = 1'b1;
  logic         clear   = 1'b0;
  logic         capture = 1'b0;
  logic         ready   = 1'b0;
  logic [W-1:0] dataIn  = '0;

  logic msbSer, msbValid, msbStart, msbDone, msbBusy, msbOvr;
  logic lsbSer, lsbValid, lsbStart, lsbDone, lsbBusy, lsbOvr;
  logic [5:0] msbVec, lsbVec;

  assign msbVec = {msbSer, msbValid, msbStart, msbDone, msbBusy, msbOvr};
  assign lsbVec = {lsbSer, lsbValid, lsbStart, lsbDone, lsbBusy, lsbOvr};

  always #5 clock = ~clock;

  par_to_ser_reader #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
    .clock(clock), .reset(reset), .clear(clear), .capture(capture), .data_in(dataIn),
    .ready(ready), .serial_out(msbSer), .serial_valid(msbValid), .frame_start(msbStart),
    .frame_done(msbDone), .busy(msbBusy), .overrun(msbOvr)
  );

  par_to_ser_reader #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
    .clock(clock), .reset(reset), .clear(clear), .capture(capture), .data_in(dataIn),
    .ready(ready), .serial_out(lsbSer), .serial_valid(lsbValid), .frame_start(lsbStart),
    .frame_done(lsbDone), .busy(lsbBusy), .overrun(lsbOvr)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the captured word plus how many of its bits have been accepted.
  bit           mBusy = 1'b0;
  logic [W-1:0] mWord = '0;
  int           mIdx  = 0;
  bit           mOvr  = 1'b0;
  bit           mDone = 1'b0;

  bit qMsb[$];
  bit qLsb[$];

  typedef struct {
    logic         cap;
    logic         rdy;
    logic [W-1:0] data;
    logic [5:0]   exp;
  } vec_t;

  vec_t basic[10];

  function automatic logic modelBit(input logic [W-1:0] word, input int idx, input bit msbFirst);
    return msbFirst ? word[W-1-idx] : word[idx];
  endfunction

  function automatic logic [W-1:0] assemble(input bit q[$], input bit msbFirst);
    logic [W-1:0] w = '0;
    for (int i = 0; i < q.size() && i < W; i++) begin
      if (msbFirst) w[W-1-i] = q[i];
      else          w[i]     = q[i];
    end
    return w;
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [5:0] expMsb, expLsb;
    if (mBusy) begin
      expMsb = {modelBit(mWord, mIdx, 1'b1), 1'b1, (mIdx == 0), mDone, 1'b1, mOvr};
      expLsb = {modelBit(mWord, mIdx, 1'b0), 1'b1, (mIdx == 0), mDone, 1'b1, mOvr};
    end else begin
      expMsb = {4'b0000, 1'b0, mOvr} | {3'b000, mDone, 2'b00};
      expLsb = expMsb;
    end
    compare({tag, " msb outputs"}, 32'(msbVec), 32'(expMsb));
    compare({tag, " lsb outputs"}, 32'(lsbVec), 32'(expLsb));
  endtask

  task automatic applyStimulus(input logic clr, input logic cap, input logic rdy,
                               input logic [W-1:0] din, input string tag);
    bit nDone;
    clear   = clr;
    capture = cap;
    ready   = rdy;
    dataIn  = din;
    if (!clr && rdy && msbValid) qMsb.push_back(msbSer);
    if (!clr && rdy && lsbValid) qLsb.push_back(lsbSer);
    nDone = 1'b0;
    if (clr) begin
      mBusy = 1'b0; mIdx = 0; mWord = '0; mOvr = 1'b0;
    end else if (!mBusy) begin
      if (cap) begin
        mBusy = 1'b1; mWord = din; mIdx = 0;
      end
    end else begin
      if (cap) mOvr = 1'b1;
      if (rdy) begin
        if (mIdx == W - 1) begin
          mBusy = 1'b0; mIdx = 0; nDone = 1'b1;
        end else begin
          mIdx++;
        end
      end
    end
    mDone = nDone;
    @(posedge clock);
    #1;
    checkOutput(tag);
  endtask

  task automatic applyReset(input string tag);
    reset = 1'b1;
    #2;
    mBusy = 1'b0; mWord = '0; mIdx = 0; mOvr = 1'b0; mDone = 1'b0;
    compare({tag, " msb during reset"}, 32'(msbVec), 32'd0);
    compare({tag, " lsb during reset"}, 32'(lsbVec), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput({tag, " after reset"});
  endtask

  task automatic runFrame(input string tag);
    for (int n = 0; n < 4 * W && mBusy; n++) applyStimulus(1'b0, 1'b0, 1'b1, '0, tag);
  endtask

  initial begin
    int busyCycles;

    basic[0] = '{1'b1, 1'b1, 8'hA5, 6'b111010};
    basic[1] = '{1'b0, 1'b1, 8'h00, 6'b010010};
    basic[2] = '{1'b0, 1'b1, 8'h00, 6'b110010};
    basic[3] = '{1'b0, 1'b1, 8'h00, 6'b010010};
    basic[4] = '{1'b0, 1'b1, 8'h00, 6'b010010};
    basic[5] = '{1'b0, 1'b1, 8'h00, 6'b110010};
    basic[6] = '{1'b0, 1'b1, 8'h00, 6'b010010};
    basic[7] = '{1'b0, 1'b1, 8'h00, 6'b110010};
    basic[8] = '{1'b0, 1'b1, 8'h00, 6'b000100};
    basic[9] = '{1'b0, 1'b1, 8'h00, 6'b000000};

    repeat (2) @(posedge clock);
    #1;
    checkOutput("power-on reset");
    reset = 1'b0;

    // Basic MSB-first frame of 8'hA5, checked row by row.
    qMsb.delete(); qLsb.delete();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, basic[i].cap, basic[i].rdy, basic[i].data, "basic");
      compare($sformatf("basic row %0d", i), 32'(msbVec), 32'(basic[i].exp));
    end
    compare("basic msb word", 32'(assemble(qMsb, 1'b1)), 32'hA5);
    compare("basic lsb word", 32'(assemble(qLsb, 1'b0)), 32'hA5);
    compare("basic bit count", qMsb.size(), W);

    // Backpressure on bits 2-4, three stalled cycles each.
    qMsb.delete(); qLsb.delete();
    busyCycles = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h81, "bp capture");
    if (msbBusy) busyCycles++;
    for (int k = 0; k < W; k++) begin
      if (k >= 1 && k <= 3) begin
        for (int s = 0; s < 3; s++) begin
          applyStimulus(1'b0, 1'b0, 1'b0, $urandom, "bp stall");
          if (msbBusy) busyCycles++;
        end
      end
      applyStimulus(1'b0, 1'b0, 1'b1, $urandom, "bp go");
      if (msbBusy) busyCycles++;
    end
    compare("bp frame length", busyCycles, 17);
    compare("bp msb word", 32'(assemble(qMsb, 1'b1)), 32'h81);
    compare("bp lsb word", 32'(assemble(qLsb, 1'b0)), 32'h81);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, "bp idle");

    // LSB-first ordering of 8'h01.
    qMsb.delete(); qLsb.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h01, "lsb capture");
    compare("lsb first bit", 32'(lsbSer), 32'd1);
    runFrame("lsb frame");
    compare("lsb word", 32'(assemble(qLsb, 1'b0)), 32'h01);

    // Overrun during a frame, then back-to-back capture in the frame_done cycle.
    qMsb.delete(); qLsb.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, "ovr capture");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, "ovr bit");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, "ovr recapture");
    runFrame("ovr frame");
    compare("ovr done pulse", 32'(msbDone), 32'd1);
    compare("ovr word kept", 32'(assemble(qMsb, 1'b1)), 32'hA5);
    compare("ovr flag", 32'(msbOvr), 32'd1);
    qMsb.delete(); qLsb.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C, "b2b capture");
    compare("b2b start", 32'({msbValid, msbStart}), 32'b11);
    runFrame("b2b frame");
    compare("b2b word", 32'(assemble(qMsb, 1'b1)), 32'h3C);
    compare("b2b overrun held", 32'(msbOvr), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, "ovr clear");
    compare("ovr cleared", 32'(msbOvr), 32'd0);

    // Clear mid-frame beats a simultaneous capture and transfer.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hC3, "clr capture");
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b1, '0, "clr bits");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h55, "clr abort");
    compare("clr idle", 32'({msbValid, msbBusy, msbDone}), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, "clr after");
    compare("clr no done", 32'(msbDone), 32'd0);
    qMsb.delete(); qLsb.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C, "clr recapture");
    runFrame("clr frame");
    compare("clr new word", 32'(assemble(qMsb, 1'b1)), 32'h3C);
    compare("clr new lsb word", 32'(assemble(qLsb, 1'b0)), 32'h3C);

    // Reset mid-frame aborts without a done pulse.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hE7, "rst capture");
    applyStimulus(1'b0, 1'b0, 1'b1, '0, "rst bit");
    applyReset("mid-frame");
    applyStimulus(1'b0, 1'b0, 1'b1, '0, "rst idle");

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) != 0), W'($urandom), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
